// File: rtl/led_pwm_driver_pkg.sv
// Shared definitions for the LED PWM driver: period length, duty type and
// the prescaler width rule.
package led_pwm_driver_pkg;

    localparam int c_pwm_steps = 255;

    typedef logic [7:0] t_pwm_duty;

    // A counter for a single-clock step still needs one bit to exist.
    function automatic int presc_width(input int clocks);
        return (clocks > 1) ? $clog2(clocks) : 1;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM filament: duty register latched at the period boundary, compared
// against the shared step counter, output registered.
module led_pwm_channel
    import led_pwm_driver_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_srst,
    input  logic      i_load,
    input  t_pwm_duty i_value,
    input  t_pwm_duty i_step,
    output logic      eo_pwm
);

    t_pwm_duty duty;

    // The compare on the load cycle still uses the old duty, so the new value
    // first shows up on the output one cycle after o_period_start.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            duty   <= '0;
            eo_pwm <= 1'b0;
        end else begin
            if (i_load) begin
                duty <= i_value;
            end
            eo_pwm <= (i_step < duty);
        end
    end

endmodule

// File: rtl/led_pwm_driver.sv
// PWM driver for the board LEDs: shared prescaler, 255-step counter and
// period load strobe, fanned out to one channel per filament.
module led_pwm_driver
    import led_pwm_driver_pkg::*;
#(
    parameter int parm_color_led_count = 4,
    parameter int parm_basic_led_count = 4,
    parameter int parm_step_clocks     = 157,
    parameter int c_color_value_upper  = 8*parm_color_led_count-1,
    parameter int c_basic_value_upper  = 8*parm_basic_led_count-1
) (
    input  logic                            i_clk,
    input  logic                            i_srst,
    input  logic [c_color_value_upper:0]    i_color_led_red_value,
    input  logic [c_color_value_upper:0]    i_color_led_green_value,
    input  logic [c_color_value_upper:0]    i_color_led_blue_value,
    input  logic [c_basic_value_upper:0]    i_basic_led_lumin_value,
    output logic [parm_color_led_count-1:0] eo_color_leds_r,
    output logic [parm_color_led_count-1:0] eo_color_leds_g,
    output logic [parm_color_led_count-1:0] eo_color_leds_b,
    output logic [parm_basic_led_count-1:0] eo_basic_leds_l,
    output logic                            o_period_start
);

    localparam int c_channels = 3*parm_color_led_count + parm_basic_led_count;
    localparam int c_pw       = presc_width(parm_step_clocks);
    localparam int c_cc       = parm_color_led_count;

    logic [c_pw-1:0]         prescaler;
    t_pwm_duty               step_count;
    logic                    first_cycle;
    logic                    step_tick;
    logic                    period_load;
    logic [8*c_channels-1:0] all_values;
    logic [c_channels-1:0]   all_pwm;

    assign step_tick   = (prescaler == c_pw'(parm_step_clocks-1));
    assign period_load = first_cycle ||
                         (step_tick && (step_count == t_pwm_duty'(c_pwm_steps-1)));

    // A load always restarts the period at step 0, which also covers the
    // fresh latch taken on the first cycle after reset release.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            prescaler      <= '0;
            step_count     <= '0;
            first_cycle    <= 1'b1;
            o_period_start <= 1'b0;
        end else begin
            first_cycle    <= 1'b0;
            o_period_start <= period_load;
            if (period_load) begin
                prescaler  <= '0;
                step_count <= '0;
            end else if (step_tick) begin
                prescaler  <= '0;
                step_count <= step_count + 8'd1;
            end else begin
                prescaler  <= prescaler + 1'b1;
            end
        end
    end

    // Channel order: red, green, blue, then basic luminance.
    assign all_values = {i_basic_led_lumin_value, i_color_led_blue_value,
                         i_color_led_green_value, i_color_led_red_value};

    for (genvar n = 0; n < c_channels; n++) begin : g_chan
        led_pwm_channel u_chan (
            .i_clk   (i_clk),
            .i_srst  (i_srst),
            .i_load  (period_load),
            .i_value (all_values[8*n +: 8]),
            .i_step  (step_count),
            .eo_pwm  (all_pwm[n])
        );
    end

    assign eo_color_leds_r = all_pwm[c_cc-1:0];
    assign eo_color_leds_g = all_pwm[2*c_cc-1:c_cc];
    assign eo_color_leds_b = all_pwm[3*c_cc-1:2*c_cc];
    assign eo_basic_leds_l = all_pwm[c_channels-1:3*c_cc];

endmodule
